// File: rtl/vgg_stage_sequencer.sv
// rtl/vgg_stage_sequencer.sv - launches enabled network stages in order for each requested frame
// Pending requests are only a count; the stage mask is captured when a frame actually starts.
module vgg_stage_sequencer #(
   parameter int NUM_STAGES      = 6,
   parameter int TIMEOUT_CYCLES  = 1048576,
   parameter int QUEUE_DEPTH     = 2,
   parameter int FRAME_CNT_WIDTH = 16,
   localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   localparam int QUEUE_W = $clog2(QUEUE_DEPTH + 1),
   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_valid,
   input  logic [NUM_STAGES-1:0]      i_stage_enable,
   input  logic [NUM_STAGES-1:0]      i_stage_done,
   input  logic                       i_clear,
   output logic [NUM_STAGES-1:0]      o_stage_start,
   output logic                       o_valid,
   output logic                       o_busy,
   output logic                       o_error,
   output logic [STAGE_W-1:0]         o_err_stage,
   output logic [STAGE_W-1:0]         o_cur_stage,
   output logic [QUEUE_W-1:0]         o_queue_cnt,
   output logic                       o_drop,
   output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ERROR} state_t;

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [QUEUE_W-1:0] QUEUE_FULL = QUEUE_W'(QUEUE_DEPTH);

   state_t                     state, state_nx;
   logic [NUM_STAGES-1:0]      mask, mask_nx;
   logic [TIMER_W-1:0]         timer, timer_nx;
   logic [STAGE_W-1:0]         cur_nx, err_stage_nx;
   logic [QUEUE_W-1:0]         queue_nx;
   logic [FRAME_CNT_WIDTH-1:0] frame_nx;
   logic                       error_nx, complete_nx, drop_nx, busy_nx;
   logic [NUM_STAGES-1:0]      start_nx;

   logic                       lo_found, hi_found;
   logic [STAGE_W-1:0]         lo_idx, hi_idx;

   // lo: first stage of a new frame (from the live mask); hi: next stage above the current one
   always_comb begin
      lo_found = 1'b0;
      lo_idx   = '0;
      hi_found = 1'b0;
      hi_idx   = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (i_stage_enable[i]) begin
            lo_found = 1'b1;
            lo_idx   = STAGE_W'(i);
         end
         if (mask[i] && (STAGE_W'(i) > o_cur_stage)) begin
            hi_found = 1'b1;
            hi_idx   = STAGE_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         mask          <= '0;
         timer         <= '0;
         o_stage_start <= '0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
         o_error       <= 1'b0;
         o_err_stage   <= '0;
         o_cur_stage   <= '0;
         o_queue_cnt   <= '0;
         o_drop        <= 1'b0;
         o_frame_cnt   <= '0;
      end else begin
         state         <= state_nx;
         mask          <= mask_nx;
         timer         <= timer_nx;
         o_stage_start <= start_nx;
         o_valid       <= complete_nx;
         o_busy        <= busy_nx;
         o_error       <= error_nx;
         o_err_stage   <= err_stage_nx;
         o_cur_stage   <= cur_nx;
         o_queue_cnt   <= queue_nx;
         o_drop        <= drop_nx;
         o_frame_cnt   <= frame_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      mask_nx      = mask;
      timer_nx     = timer;
      cur_nx       = o_cur_stage;
      err_stage_nx = o_err_stage;
      queue_nx     = o_queue_cnt;
      error_nx     = o_error;
      complete_nx  = 1'b0;
      drop_nx      = 1'b0;
      case (state)
         S_IDLE: begin
            if ((o_queue_cnt != '0) || i_valid) begin
               // a live request arriving alongside a queued one takes its queue slot
               if ((o_queue_cnt != '0) && !i_valid)
                  queue_nx = o_queue_cnt - QUEUE_W'(1);
               mask_nx = i_stage_enable;
               if (lo_found) begin
                  state_nx = S_LAUNCH;
                  cur_nx   = lo_idx;
               end else begin
                  complete_nx = 1'b1;
               end
            end
         end
         S_LAUNCH, S_WAIT: begin
            if (i_valid) begin
               if (o_queue_cnt == QUEUE_FULL)
                  drop_nx = 1'b1;
               else
                  queue_nx = o_queue_cnt + QUEUE_W'(1);
            end
            if (state == S_LAUNCH) begin
               timer_nx = '0;
               state_nx = S_WAIT;
            end else if (i_stage_done[o_cur_stage]) begin
               if (hi_found) begin
                  state_nx = S_LAUNCH;
                  cur_nx   = hi_idx;
               end else begin
                  state_nx    = S_IDLE;
                  complete_nx = 1'b1;
               end
            end else if (timer == TIMER_LAST) begin
               state_nx     = S_ERROR;
               error_nx     = 1'b1;
               err_stage_nx = o_cur_stage;
            end else begin
               timer_nx = timer + TIMER_W'(1);
            end
         end
         S_ERROR: begin
            drop_nx = i_valid;
            if (i_clear) begin
               queue_nx = '0;
               error_nx = 1'b0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      frame_nx = complete_nx ? (o_frame_cnt + FRAME_CNT_WIDTH'(1)) : o_frame_cnt;
   end

   always_comb begin
      start_nx = '0;
      if (state_nx == S_LAUNCH)
         start_nx = NUM_STAGES'(1) << cur_nx;
      busy_nx = (state_nx != S_IDLE);
   end

endmodule

// File: tb/tb_vgg_stage_sequencer.sv
// tb/tb_vgg_stage_sequencer.sv - randomized scoreboard bench for vgg_stage_sequencer
module tb_vgg_stage_sequencer;
   localparam int NS = 6;
   localparam int TO = 16;
   localparam int QD = 2;
   localparam int FW = 16;
   localparam int SW = 3;
   localparam int QW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_valid, i_clear;
   logic [NS-1:0] i_stage_enable;
   logic [NS-1:0] i_stage_done = '0;
   logic [NS-1:0] o_stage_start;
   logic          o_valid, o_busy, o_error, o_drop;
   logic [SW-1:0] o_err_stage, o_cur_stage;
   logic [QW-1:0] o_queue_cnt;
   logic [FW-1:0] o_frame_cnt;

   always #5 clk = ~clk;

   vgg_stage_sequencer #(
      .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO), .QUEUE_DEPTH(QD), .FRAME_CNT_WIDTH(FW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_stage_enable(i_stage_enable),
      .i_stage_done(i_stage_done), .i_clear(i_clear), .o_stage_start(o_stage_start),
      .o_valid(o_valid), .o_busy(o_busy), .o_error(o_error), .o_err_stage(o_err_stage),
      .o_cur_stage(o_cur_stage), .o_queue_cnt(o_queue_cnt), .o_drop(o_drop),
      .o_frame_cnt(o_frame_cnt)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int drops_seen = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: a frame is the list of enabled stage indices, walked one by one
   typedef struct { int cyc; int val; } ev_t;
   ev_t start_q[$], valid_q[$], drop_q[$];
   bit  m_active, m_launch, m_err;
   int  m_pend, m_cur, m_wait, m_err_stage, m_frames;
   int  m_todo[$];

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_active = 0; m_launch = 0; m_err = 0; m_pend = 0; m_cur = 0;
         m_wait = 0; m_err_stage = 0; m_frames = 0; m_todo.delete();
      end else if (m_err) begin
         if (i_valid) drop_q.push_back('{cyc, 0});
         if (i_clear) begin m_err = 0; m_pend = 0; end
      end else if (!m_active) begin
         if (m_pend > 0 || i_valid) begin
            if (!i_valid) m_pend--;
            m_todo.delete();
            for (int s = 0; s < NS; s++) if (i_stage_enable[s]) m_todo.push_back(s);
            if (m_todo.size() == 0) begin
               m_frames++;
               valid_q.push_back('{cyc, m_frames % (1 << FW)});
            end else begin
               m_cur = m_todo.pop_front(); m_active = 1; m_launch = 1;
               start_q.push_back('{cyc, m_cur});
            end
         end
      end else begin
         if (i_valid) begin
            if (m_pend == QD) drop_q.push_back('{cyc, 0});
            else m_pend++;
         end
         if (m_launch) begin
            m_launch = 0; m_wait = 0;
         end else if (i_stage_done[m_cur]) begin
            if (m_todo.size() > 0) begin
               m_cur = m_todo.pop_front(); m_launch = 1;
               start_q.push_back('{cyc, m_cur});
            end else begin
               m_active = 0; m_frames++;
               valid_q.push_back('{cyc, m_frames % (1 << FW)});
            end
         end else if (m_wait == TO - 1) begin
            m_err = 1; m_err_stage = m_cur; m_active = 0;
         end else begin
            m_wait++;
         end
      end
   end

   // monitor: pops expected events whenever the DUT presents one
   ev_t mon_e;
   logic [2+2*SW+QW+FW-1:0] exp_status;
   always @(negedge clk) begin
      if (cyc > 0) begin
         while (start_q.size() > 0 && start_q[0].cyc < cyc) begin
            mon_e = start_q.pop_front(); chk("start_missing", cyc, mon_e.cyc);
         end
         while (valid_q.size() > 0 && valid_q[0].cyc < cyc) begin
            mon_e = valid_q.pop_front(); chk("valid_missing", cyc, mon_e.cyc);
         end
         while (drop_q.size() > 0 && drop_q[0].cyc < cyc) begin
            mon_e = drop_q.pop_front(); chk("drop_missing", cyc, mon_e.cyc);
         end
         if (o_stage_start != '0) begin
            if (start_q.size() == 0) chk("start_unexpected", o_stage_start, 0);
            else begin
               mon_e = start_q.pop_front();
               chk("start_cycle", cyc, mon_e.cyc);
               chk("start_onehot", o_stage_start, 1 << mon_e.val);
            end
         end
         if (o_valid) begin
            if (valid_q.size() == 0) chk("valid_unexpected", o_valid, 0);
            else begin
               mon_e = valid_q.pop_front();
               chk("valid_cycle", cyc, mon_e.cyc);
               chk("valid_frame_cnt", o_frame_cnt, mon_e.val);
            end
         end
         if (o_drop) begin
            drops_seen++;
            if (drop_q.size() == 0) chk("drop_unexpected", o_drop, 0);
            else begin
               mon_e = drop_q.pop_front();
               chk("drop_cycle", cyc, mon_e.cyc);
            end
         end
         exp_status = {m_active || m_err, m_err, SW'(m_err_stage), SW'(m_cur), QW'(m_pend), FW'(m_frames)};
         chk("status", {o_busy, o_error, o_err_stage, o_cur_stage, o_queue_cnt, o_frame_cnt}, exp_status);
      end
   end

   // stage responder: answers each launch with a done after a chosen delay
   int  rsp_delay = 3;
   bit  rsp_rand = 0, stray_en = 0, noise_en = 0;
   int  hold_stage = -1;
   bit  rsp_pend = 0, stray_pend = 0;
   int  rsp_cd = 0, rsp_stage = 0;
   logic [NS-1:0] done_v;

   always @(negedge clk) begin
      if (!rst_n) begin
         rsp_pend = 0; stray_pend = 0;
      end else if (o_stage_start != '0) begin
         for (int s = 0; s < NS; s++) if (o_stage_start[s]) rsp_stage = s;
         rsp_cd   = rsp_rand ? int'($urandom_range(1, 18)) : rsp_delay;
         rsp_pend = (rsp_stage != hold_stage);
         if (stray_en && rsp_stage == 1) stray_pend = 1;
      end
   end

   always @(posedge clk) begin
      #1;
      done_v = '0;
      if (rsp_pend) begin
         rsp_cd--;
         if (rsp_cd == 0) begin done_v[rsp_stage] = 1'b1; rsp_pend = 0; end
      end
      if (stray_pend) begin done_v[4] = 1'b1; stray_pend = 0; end
      if (noise_en && $urandom_range(0, 19) == 0) done_v[$urandom_range(0, NS - 1)] = 1'b1;
      i_stage_done = done_v;
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_valid();
      i_valid = 1'b1; step(); i_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((m_active || m_err || m_pend != 0) && n < limit) begin step(); n++; end
      chk("idle_reached", {m_active, m_err, m_pend != 0}, 0);
      step(2);
   endtask

   int n0;
   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_stage_enable = '1;
      step(3);
      chk("reset_outputs", {o_stage_start, o_valid, o_busy, o_error, o_drop, o_err_stage,
                            o_cur_stage, o_queue_cnt, o_frame_cnt}, 0);
      rst_n = 1'b1;
      step(2);

      // full chain, with an i_clear outside ERROR that must be ignored
      i_stage_enable = 6'b111111; rsp_delay = 3;
      pulse_valid();
      step(4); i_clear = 1'b1; step(); i_clear = 1'b0;
      wait_idle(200);
      chk("chain_frames", o_frame_cnt, 1);

      // bypass, mask changed mid-frame
      i_stage_enable = 6'b100101;
      pulse_valid();
      step(3); i_stage_enable = 6'b111111;
      wait_idle(200);
      chk("bypass_frames", o_frame_cnt, 2);

      // queue overflow
      rsp_delay = 2; n0 = drops_seen;
      pulse_valid(); step();
      repeat (3) begin pulse_valid(); step(); end
      chk("queue_full", o_queue_cnt, 2);
      chk("one_drop", drops_seen - n0, 1);
      wait_idle(400);
      chk("overflow_frames", o_frame_cnt, 5);

      // empty mask completes immediately
      i_stage_enable = '0;
      pulse_valid();
      wait_idle(20);
      chk("zero_mask_frames", o_frame_cnt, 6);

      // timeout on stage 3, then drop in ERROR and clear
      i_stage_enable = '1; hold_stage = 3;
      pulse_valid(); step(3); pulse_valid();
      n0 = 0;
      while (!o_error && n0 < 100) begin step(); n0++; end
      chk("error_flag", o_error, 1);
      chk("err_stage", o_err_stage, 3);
      n0 = drops_seen;
      pulse_valid(); step();
      chk("error_drop", drops_seen - n0, 1);
      i_clear = 1'b1; step(); i_clear = 1'b0;
      chk("clear_queue", o_queue_cnt, 0);
      chk("clear_error", o_error, 0);
      chk("clear_idle", o_busy, 0);
      chk("err_stage_kept", o_err_stage, 3);
      hold_stage = -1;
      step(2);

      // done on the timeout cycle, plus a stray done[4] while awaiting stage 1
      rsp_delay = TO; stray_en = 1;
      pulse_valid();
      wait_idle(400);
      chk("race_no_error", o_error, 0);
      chk("race_frames", o_frame_cnt, 7);
      stray_en = 0;

      // reset while waiting on stage 2
      rsp_delay = 5;
      pulse_valid();
      n0 = 0;
      while (!(m_active && !m_launch && m_cur == 2) && n0 < 100) begin step(); n0++; end
      rst_n = 1'b0; i_valid = 1'b1;
      step();
      rst_n = 1'b1; i_valid = 1'b0;
      chk("midframe_reset", {o_stage_start, o_valid, o_busy, o_error, o_drop, o_err_stage,
                             o_cur_stage, o_queue_cnt, o_frame_cnt}, 0);
      step();
      pulse_valid();
      wait_idle(200);
      chk("restart_frames", o_frame_cnt, 1);

      // randomized traffic
      rsp_rand = 1; noise_en = 1;
      repeat (2500) begin
         i_valid = ($urandom_range(0, 5) == 0);
         i_clear = ($urandom_range(0, 7) == 0);
         i_stage_enable = NS'($urandom);
         step();
      end
      i_valid = 1'b0; rsp_rand = 0; rsp_delay = 2; noise_en = 0; i_clear = 1'b1;
      wait_idle(600);
      i_clear = 1'b0;
      step(3);
      chk("start_q_empty", start_q.size(), 0);
      chk("valid_q_empty", valid_q.size(), 0);
      chk("drop_q_empty", drop_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
